// File: rtl/j_pit_pkg.sv
// Shared definitions for the j_pit_timer programmable interval timer:
// default counter widths, run-state encoding and read-select codes.
package j_pit_pkg;

  localparam int PRE_W = 16;
  localparam int DIV_W = 16;

  typedef enum logic {
    PIT_IDLE = 1'b0,
    PIT_RUN  = 1'b1
  } pit_state_e;

  localparam logic RD_PRE = 1'b0;
  localparam logic RD_DIV = 1'b1;

endpackage

// File: rtl/j_pit_dcnt.sv
// Reusable down-counter with reload. A zero count reloads from rld_val on the
// next step instead of wrapping, so the counter never goes below zero.
// An explicit load overrides stepping.
module j_pit_dcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] rld_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement or reload at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (step) begin
      if (cnt_q == '0) cnt_d = rld_val;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/j_pit_timer.sv
// Programmable interval timer: a prescaler cascaded into a divider, emitting a
// one-cycle registered tick on each divider expiry.
// Build option: J_PIT_READBACK_EN makes rd_data a registered view of the live
// counters; without it rd_data shows the reload registers combinationally.
module j_pit_timer
  import j_pit_pkg::*;
#(
  parameter int PRE_W = j_pit_pkg::PRE_W,
  parameter int DIV_W = j_pit_pkg::DIV_W
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        clock_en,
  input  logic        wr_pre,
  input  logic        wr_div,
  input  logic [15:0] wr_data,
  input  logic        rd_sel,
  output logic [15:0] rd_data,
  output logic        running,
  output logic        tick
);

  pit_state_e       state_q, state_d;
  logic             running_q, running_d;
  logic             tick_q, tick_d;
  logic [PRE_W-1:0] pre_rld_q, pre_rld_d;
  logic [DIV_W-1:0] div_rld_q, div_rld_d;
  logic [PRE_W-1:0] pre_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             pre_zero, div_zero;
  logic             cnt_load, advance, pre_wrap, div_wrap;

  // Register-port updates, count qualification and expiry detection.
  // Any write suppresses counting that cycle, so a write on an expiry
  // cycle cancels the tick.
  always_comb begin
    pre_rld_d = wr_pre ? wr_data[PRE_W-1:0] : pre_rld_q;
    div_rld_d = wr_div ? wr_data[DIV_W-1:0] : div_rld_q;
    cnt_load  = wr_pre | wr_div;
    advance   = running_q & clock_en & ~cnt_load;
    pre_wrap  = advance & pre_zero;
    div_wrap  = pre_wrap & div_zero;
    tick_d    = div_wrap;
    state_d   = state_q;
    if (wr_pre) begin
      state_d = (wr_data[PRE_W-1:0] != '0) ? PIT_RUN : PIT_IDLE;
    end
    running_d = (state_d == PIT_RUN);
  end

  // Run state, registered outputs and reload registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= PIT_IDLE;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      pre_rld_q <= '0;
      div_rld_q <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      pre_rld_q <= pre_rld_d;
      div_rld_q <= div_rld_d;
    end
  end

  // Any write restarts the full period: each counter loads its (possibly
  // new) reload value.
  j_pit_dcnt #(.W(PRE_W)) u_pre (
    .clk      (sys_clk),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .load_val (pre_rld_d),
    .step     (advance),
    .rld_val  (pre_rld_q),
    .cnt      (pre_cnt),
    .zero     (pre_zero)
  );

  j_pit_dcnt #(.W(DIV_W)) u_div (
    .clk      (sys_clk),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .load_val (div_rld_d),
    .step     (pre_wrap),
    .rld_val  (div_rld_q),
    .cnt      (div_cnt),
    .zero     (div_zero)
  );

`ifdef J_PIT_READBACK_EN
  logic [15:0] rd_q, rd_d;

  // Select the live counter to present one cycle later.
  always_comb begin
    rd_d = (rd_sel == RD_DIV) ? 16'(div_cnt) : 16'(pre_cnt);
  end

  // Read-data register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) rd_q <= '0;
    else          rd_q <= rd_d;
  end

  assign rd_data = rd_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^{pre_cnt, div_cnt};
  assign rd_data    = (rd_sel == RD_DIV) ? 16'(div_rld_q) : 16'(pre_rld_q);
`endif

  assign running = running_q;
  assign tick    = tick_q;

endmodule

// File: doc/j_pit_timer.md
Name: j_pit_timer

Overview:
- Programmable interval timer for the Jerry audio subsystem.
- A 16-bit prescaler cascades into a 16-bit divider. On each divider expiry the block emits a single-cycle `tick` pulse.
- `tick` drives the `set` input of the downstream clocked set/clear interrupt latch. The CPU clears that latch separately.
- The reload registers and the live counters are accessed through a simple strobe-based register port.

Parameters:
- PRE_W, 16, width of the prescaler reload register and prescaler counter.
- DIV_W, 16, width of the divider reload register and divider counter.

Ports:
- sys_clk  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clock_en  in  1  count-enable qualifier. Counters advance only on cycles where it is high.
- wr_pre  in  1  write strobe: load `wr_data[PRE_W-1:0]` into the prescaler reload register.
- wr_div  in  1  write strobe: load `wr_data[DIV_W-1:0]` into the divider reload register.
- wr_data  in  16  write data.
- rd_sel  in  1  read select: 0 = prescaler counter, 1 = divider counter.
- rd_data  out  16  read data, zero-extended.
- running  out  1  high while the timer is enabled.
- tick  out  1  one-cycle expiry pulse, registered.

Behaviour:
- Reset, asynchronous while `reset_n` is low:
  - `pre_rld`, `div_rld`, `pre_cnt`, `div_cnt` all go to 0.
  - `tick` = 0, `running` = 0, `rd_data` = 0.
  - Reset released mid-count discards all state; nothing is resumed.
- Enable rule:
  - `running` = (`pre_rld` != 0), registered, so it is valid the cycle after the write.
  - Writing 0 to the prescaler stops the timer.
  - A `div_rld` value of 0 is legal and gives a period of 1 × prescaler.
- Counting, on a cycle with `running`=1 and `clock_en`=1:
  - If `pre_cnt` != 0: `pre_cnt` decrements by 1.
  - Else `pre_cnt` reloads from `pre_rld`, and the divider steps:
    - If `div_cnt` != 0: `div_cnt` decrements by 1.
    - Else `div_cnt` reloads from `div_rld` and `tick` is asserted on the next cycle.
- Period: (`pre_rld`+1) × (`div_rld`+1) enabled cycles between ticks.
- `tick` latency: registered, high for exactly one `sys_clk` cycle, starting on the edge after the expiry cycle. The pulse is never stretched.
- `clock_en` low: all counters hold and no tick is produced. A tick already registered still completes its single cycle.
- Write `wr_pre`:
  - `pre_rld` and `pre_cnt` both load `wr_data`.
  - `div_cnt` loads the current `div_rld`, which restarts the full period.
- Write `wr_div`:
  - `div_rld` and `div_cnt` load `wr_data`.
  - `pre_cnt` reloads from `pre_rld`.
- Simultaneous `wr_pre` and `wr_div`: both reload registers update; both counters load their new values.
- Write coinciding with an expiry: the write wins. No tick is generated for that cycle and no decrement is applied.
- Counter wrap: counters never decrement below 0, because a zero value always triggers a reload.
- Stopped state (`running`=0):
  - Counters hold their values.
  - `tick` is held at 0, except for a tick already registered in the cycle the stop takes effect, which completes normally.
- Internal state: two states.
  - IDLE: `running`=0.
  - RUN: `running`=1.
  - IDLE→RUN on a nonzero `wr_pre`. RUN→IDLE on `wr_pre` with data 0. Reset forces IDLE.

Optional Feature:
- Macro: `J_PIT_READBACK_EN`.
- Defined: `rd_data` is a registered mux of `pre_cnt` / `div_cnt` selected by `rd_sel`, with one cycle of latency.
- Undefined: `rd_data` returns the reload registers (`pre_rld` / `div_rld`) combinationally. The live counters are not observable, which saves the read mux flops.

Decomposition:
- Shared package `j_pit_pkg`: default widths `PRE_W`/`DIV_W`; state encoding constants `PIT_IDLE`=1'b0, `PIT_RUN`=1'b1; read-select constants `RD_PRE`=0, `RD_DIV`=1.
- One sub-module: `j_pit_dcnt`, a reusable down-counter with reload. It has inputs load, load_val, step, rld_val and a zero-flag output. It is instantiated twice, once for the prescaler and once for the divider; the divider instance's step is the prescaler's zero-and-step.

Test Plan:
- Reset: hold `reset_n`=0 with random strobes → `tick`=0, `running`=0, `rd_data`=0. Release → state unchanged until the first write.
- Basic period: `wr_pre`=2, `wr_div`=3, `clock_en`=1 constant → first tick 12 cycles after the write; ticks recur every 12 cycles; each tick is 1 cycle wide.
- Gating: same setup with `clock_en` toggling 1/0 every cycle → tick period is 24 `sys_clk` cycles; counters hold on `clock_en`=0 cycles (checked with `J_PIT_READBACK_EN`).
- Stop and restart: write `wr_pre`=0 mid-period → `running`=0 next cycle and no further ticks. Write `wr_pre`=1 → `running`=1; next tick after (1+1)×(`div_rld`+1) cycles.
- Write/expiry collision: arrange `wr_div`=5 on the exact expiry cycle → no tick that cycle; next tick after (`pre_rld`+1)×6 cycles.
- Async reset mid-count: assert `reset_n`=0 asynchronously, between `sys_clk` edges, one cycle before expiry → `tick` never asserts; all outputs 0 immediately.
